// File: rtl/div_pkg.sv
// Shared types and constants for the integer divider reservation station.
package div_pkg;

  localparam int TAG_W = 8;

  localparam logic [3:0] DIV_OP_QUO = 4'b0001;
  localparam logic [3:0] DIV_OP_REM = 4'b0000;

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [31:0]      pc;
    logic [TAG_W-1:0] pdst;
    logic [TAG_W-1:0] src1_tag;
    logic [31:0]      src1_val;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic [31:0]      src2_val;
    logic             src2_rdy;
  } div_rs_entry_t;

endpackage

// File: rtl/div_rs_if.sv
// Dispatch, CDB and issue signals of the divider reservation station.
interface div_rs_if import div_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int TAG_W = div_pkg::TAG_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             dispatch_valid;
  logic [3:0]       dispatch_op;
  logic [31:0]      dispatch_pc;
  logic [TAG_W-1:0] dispatch_pdst;
  logic [TAG_W-1:0] dispatch_src1_tag;
  logic [TAG_W-1:0] dispatch_src2_tag;
  logic [31:0]      dispatch_src1_val;
  logic [31:0]      dispatch_src2_val;
  logic             dispatch_src1_rdy;
  logic             dispatch_src2_rdy;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             full;
  logic [CNT_W-1:0] count;
  logic             start;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [TAG_W-1:0] Physical_address;
  logic [31:0]      PC;
  logic [3:0]       divider_op;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_pc, dispatch_pdst,
           dispatch_src1_tag, dispatch_src2_tag, dispatch_src1_val, dispatch_src2_val,
           dispatch_src1_rdy, dispatch_src2_rdy, cdb_valid, cdb_tag, cdb_value,
    input  full, count, start, A, B, Physical_address, PC, divider_op
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_pc, dispatch_pdst,
           dispatch_src1_tag, dispatch_src2_tag, dispatch_src1_val, dispatch_src2_val,
           dispatch_src1_rdy, dispatch_src2_rdy, cdb_valid, cdb_tag, cdb_value,
    output full, count, start, A, B, Physical_address, PC, divider_op
  );

endinterface

// File: rtl/div_rs_select.sv
// Find-first over the ready vector: lowest set index wins.
module div_rs_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     hit
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (req[i-1]) begin
        idx = IDX_W'(i - 1);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_rs.sv
// Collapsing-queue reservation station feeding the pipelined divider.
// Optional DIV_RS_FLUSH_EN adds a flush input that empties the station.
module div_rs import div_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int TAG_W = div_pkg::TAG_W
) (
  input  logic     clk,
  input  logic     reset,
`ifdef DIV_RS_FLUSH_EN
  input  logic     flush,
`endif
  div_rs_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  div_rs_entry_t    q     [DEPTH];
  div_rs_entry_t    sh    [DEPTH];
  div_rs_entry_t    q_nxt [DEPTH];
  div_rs_entry_t    incoming;
  logic [CNT_W-1:0] cnt, cnt_nxt, wr_idx;
  logic [DEPTH-1:0] req;
  logic [IDX_W-1:0] sel_idx;
  logic             hit, accept, flush_q;
  logic [TAG_W-1:0] cdb_tag;

`ifdef DIV_RS_FLUSH_EN
  assign flush_q = flush;
`else
  assign flush_q = 1'b0;
`endif

  assign cdb_tag   = bus.cdb_tag;
  assign bus.full  = (cnt == CNT_W'(DEPTH));
  assign bus.count = cnt;
  assign accept    = bus.dispatch_valid && !bus.full;
  assign wr_idx    = cnt - CNT_W'(hit);
  assign cnt_nxt   = cnt + CNT_W'(accept) - CNT_W'(hit);

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      req[i] = q[i].valid & q[i].src1_rdy & q[i].src2_rdy;
  end

  div_rs_select #(.DEPTH(DEPTH)) u_select (
    .req (req),
    .idx (sel_idx),
    .hit (hit)
  );

  // Incoming sources snoop the CDB so a same-cycle broadcast is not lost.
  always_comb begin
    incoming          = '0;
    incoming.valid    = 1'b1;
    incoming.op       = bus.dispatch_op;
    incoming.pc       = bus.dispatch_pc;
    incoming.pdst     = bus.dispatch_pdst;
    incoming.src1_tag = bus.dispatch_src1_tag;
    incoming.src1_val = bus.dispatch_src1_val;
    incoming.src1_rdy = bus.dispatch_src1_rdy;
    incoming.src2_tag = bus.dispatch_src2_tag;
    incoming.src2_val = bus.dispatch_src2_val;
    incoming.src2_rdy = bus.dispatch_src2_rdy;
    if (bus.cdb_valid && !bus.dispatch_src1_rdy && bus.dispatch_src1_tag == cdb_tag) begin
      incoming.src1_rdy = 1'b1;
      incoming.src1_val = bus.cdb_value;
    end
    if (bus.cdb_valid && !bus.dispatch_src2_rdy && bus.dispatch_src2_tag == cdb_tag) begin
      incoming.src2_rdy = 1'b1;
      incoming.src2_val = bus.cdb_value;
    end
  end

  // Collapse above the winner, then apply wakeup and the dispatch write.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++)
      sh[i] = (hit && CNT_W'(i) >= CNT_W'(sel_idx)) ? q[i+1] : q[i];
    sh[DEPTH-1] = hit ? '0 : q[DEPTH-1];

    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_nxt[i] = sh[i];
      if (bus.cdb_valid && sh[i].valid) begin
        if (!sh[i].src1_rdy && sh[i].src1_tag == cdb_tag) begin
          q_nxt[i].src1_rdy = 1'b1;
          q_nxt[i].src1_val = bus.cdb_value;
        end
        if (!sh[i].src2_rdy && sh[i].src2_tag == cdb_tag) begin
          q_nxt[i].src2_rdy = 1'b1;
          q_nxt[i].src2_val = bus.cdb_value;
        end
      end
      if (accept && CNT_W'(i) == wr_idx)
        q_nxt[i] = incoming;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        q[i] <= '0;
      cnt                  <= '0;
      bus.start            <= 1'b0;
      bus.A                <= '0;
      bus.B                <= '0;
      bus.Physical_address <= '0;
      bus.PC               <= '0;
      bus.divider_op       <= '0;
    end else if (flush_q) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        q[i] <= '0;
      cnt       <= '0;
      bus.start <= 1'b0;
    end else begin
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      bus.start <= hit;
      if (hit) begin
        bus.A                <= q[sel_idx].src1_val;
        bus.B                <= q[sel_idx].src2_val;
        bus.Physical_address <= q[sel_idx].pdst;
        bus.PC               <= q[sel_idx].pc;
        bus.divider_op       <= q[sel_idx].op;
      end
    end
  end

endmodule

// File: tb/tb_div_rs.sv
// Directed bench for div_rs: table of pass-through vectors plus ordering/wakeup/full sequences.
module tb_div_rs;
  import div_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
`ifdef DIV_RS_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  div_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus();

  div_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef DIV_RS_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [7:0]  pdst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  e_op;
    logic [31:0] e_pc;
    logic [7:0]  e_pa;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t vecs [4];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid    = 1'b0;
    bus.dispatch_op       = '0;
    bus.dispatch_pc       = '0;
    bus.dispatch_pdst     = '0;
    bus.dispatch_src1_tag = '0;
    bus.dispatch_src2_tag = '0;
    bus.dispatch_src1_val = '0;
    bus.dispatch_src2_val = '0;
    bus.dispatch_src1_rdy = 1'b0;
    bus.dispatch_src2_rdy = 1'b0;
    bus.cdb_valid         = 1'b0;
    bus.cdb_tag           = '0;
    bus.cdb_value         = '0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] pc, input logic [7:0] pdst,
                          input logic [7:0] t1, input logic [31:0] v1, input logic r1,
                          input logic [7:0] t2, input logic [31:0] v2, input logic r2);
    bus.dispatch_valid    = 1'b1;
    bus.dispatch_op       = op;
    bus.dispatch_pc       = pc;
    bus.dispatch_pdst     = pdst;
    bus.dispatch_src1_tag = t1;
    bus.dispatch_src1_val = v1;
    bus.dispatch_src1_rdy = r1;
    bus.dispatch_src2_tag = t2;
    bus.dispatch_src2_val = v2;
    bus.dispatch_src2_rdy = r2;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0001, 32'h40, 8'h12, 32'd100, 32'd7,
                4'b0001, 32'h40, 8'h12, 32'd100, 32'd7};
    vecs[1] = '{4'b0000, 32'h1000, 8'h01, 32'hFFFF_FFFF, 32'h0,
                4'b0000, 32'h1000, 8'h01, 32'hFFFF_FFFF, 32'h0};
    vecs[2] = '{4'hF, 32'hFFFF_FFFC, 8'hFF, 32'h8000_0000, 32'hFFFF_FFFF,
                4'hF, 32'hFFFF_FFFC, 8'hFF, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[3] = '{4'b0001, 32'h0, 8'h00, 32'h0, 32'h1,
                4'b0001, 32'h0, 8'h00, 32'h0, 32'h1};

    idle();
    reset = 1'b1;
`ifdef DIV_RS_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_start", 32'(bus.start), 0);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_PC", bus.PC, 0);
    check("rst_PA", 32'(bus.Physical_address), 0);
    check("rst_op", 32'(bus.divider_op), 0);

    for (int v = 0; v < 4; v++) begin
      dispatch(vecs[v].op, vecs[v].pc, vecs[v].pdst, 8'h00, vecs[v].a, 1'b1, 8'h00, vecs[v].b, 1'b1);
      tick();
      idle();
      check($sformatf("v%0d_count1", v), 32'(bus.count), 1);
      check($sformatf("v%0d_nostart", v), 32'(bus.start), 0);
      tick();
      check($sformatf("v%0d_start", v), 32'(bus.start), 1);
      check($sformatf("v%0d_A", v), bus.A, vecs[v].e_a);
      check($sformatf("v%0d_B", v), bus.B, vecs[v].e_b);
      check($sformatf("v%0d_PA", v), 32'(bus.Physical_address), 32'(vecs[v].e_pa));
      check($sformatf("v%0d_PC", v), bus.PC, vecs[v].e_pc);
      check($sformatf("v%0d_op", v), 32'(bus.divider_op), 32'(vecs[v].e_op));
      check($sformatf("v%0d_count0", v), 32'(bus.count), 0);
      tick();
      check($sformatf("v%0d_start_drop", v), 32'(bus.start), 0);
      check($sformatf("v%0d_A_hold", v), bus.A, vecs[v].e_a);
    end

    // CDB wakeup of src2; unrelated broadcast must not wake it
    dispatch(4'b0001, 32'h80, 8'h22, 8'h00, 32'd50, 1'b1, 8'h33, 32'h0, 1'b0);
    tick();
    idle();
    check("wk_count", 32'(bus.count), 1);
    cdb(8'h34, 32'd99);
    tick();
    idle();
    check("wk_wait0", 32'(bus.start), 0);
    tick();
    check("wk_wait1", 32'(bus.start), 0);
    cdb(8'h33, 32'd5);
    tick();
    idle();
    check("wk_t1", 32'(bus.start), 0);
    tick();
    check("wk_start", 32'(bus.start), 1);
    check("wk_A", bus.A, 50);
    check("wk_B", bus.B, 5);
    check("wk_PA", 32'(bus.Physical_address), 32'h22);

    // Dispatch and matching broadcast in the same cycle
    dispatch(4'b0000, 32'h90, 8'h23, 8'h21, 32'h0, 1'b0, 8'h00, 32'd3, 1'b1);
    cdb(8'h21, 32'd9);
    tick();
    idle();
    check("sc_count", 32'(bus.count), 1);
    tick();
    check("sc_start", 32'(bus.start), 1);
    check("sc_A", bus.A, 9);
    check("sc_B", bus.B, 3);

    // Younger entry ready first issues first
    dispatch(4'b0000, 32'hA0, 8'h30, 8'h40, 32'h0, 1'b0, 8'h00, 32'd4, 1'b1);
    tick();
    dispatch(4'b0000, 32'hA4, 8'h31, 8'h41, 32'h0, 1'b0, 8'h00, 32'd4, 1'b1);
    tick();
    idle();
    cdb(8'h41, 32'd11);
    tick();
    idle();
    check("ord_wait", 32'(bus.start), 0);
    tick();
    check("ord_young_start", 32'(bus.start), 1);
    check("ord_young_PA", 32'(bus.Physical_address), 32'h31);
    check("ord_young_A", bus.A, 11);
    cdb(8'h40, 32'd12);
    tick();
    idle();
    check("ord_gap", 32'(bus.start), 0);
    tick();
    check("ord_old_PA", 32'(bus.Physical_address), 32'h30);
    check("ord_old_A", bus.A, 12);
    check("ord_count0", 32'(bus.count), 0);

    // Two entries woken by one broadcast: older first, back-to-back
    dispatch(4'b0001, 32'hB0, 8'h60, 8'h50, 32'h0, 1'b0, 8'h00, 32'd1, 1'b1);
    tick();
    dispatch(4'b0001, 32'hB4, 8'h61, 8'h50, 32'h0, 1'b0, 8'h00, 32'd2, 1'b1);
    tick();
    idle();
    cdb(8'h50, 32'd3);
    tick();
    idle();
    tick();
    check("both_first_start", 32'(bus.start), 1);
    check("both_first_PA", 32'(bus.Physical_address), 32'h60);
    check("both_first_B", bus.B, 1);
    check("both_count1", 32'(bus.count), 1);
    tick();
    check("both_second_start", 32'(bus.start), 1);
    check("both_second_PA", 32'(bus.Physical_address), 32'h61);
    check("both_second_B", bus.B, 2);
    tick();
    check("both_idle", 32'(bus.start), 0);

    // Both sources of one entry wake on a single broadcast
    dispatch(4'b0000, 32'hC0, 8'h71, 8'h70, 32'h0, 1'b0, 8'h70, 32'h0, 1'b0);
    tick();
    idle();
    cdb(8'h70, 32'd77);
    tick();
    idle();
    tick();
    check("dual_start", 32'(bus.start), 1);
    check("dual_A", bus.A, 77);
    check("dual_B", bus.B, 77);

    // Fill, reject while full (also in the issuing cycle), then drain one
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(4'b0000, 32'(i), 8'(8'h90 + i), 8'(8'h80 + i), 32'h0, 1'b0, 8'h00, 32'd2, 1'b1);
      tick();
    end
    idle();
    check("fill_count", 32'(bus.count), 8);
    check("fill_full", 32'(bus.full), 1);
    dispatch(4'b0001, 32'hEE, 8'hAA, 8'h00, 32'd1, 1'b1, 8'h00, 32'd1, 1'b1);
    cdb(8'h83, 32'd21);
    tick();
    bus.cdb_valid = 1'b0;
    check("full_drop_count", 32'(bus.count), 8);
    check("full_drop_start", 32'(bus.start), 0);
    tick();
    idle();
    check("full_issue_start", 32'(bus.start), 1);
    check("full_issue_PA", 32'(bus.Physical_address), 32'h93);
    check("full_issue_A", bus.A, 21);
    check("full_issue_count", 32'(bus.count), 7);
    check("full_deassert", 32'(bus.full), 0);
    tick();
    check("full_after_start", 32'(bus.start), 0);
    check("full_after_count", 32'(bus.count), 7);
    check("full_after_PA", 32'(bus.Physical_address), 32'h93);

    // Mid-operation reset discards in-flight dispatch and broadcast
    dispatch(4'b0001, 32'hF0, 8'hBB, 8'h00, 32'd1, 1'b1, 8'h00, 32'd1, 1'b1);
    cdb(8'h80, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_full", 32'(bus.full), 0);
    check("mrst_start", 32'(bus.start), 0);
    check("mrst_A", bus.A, 0);
    check("mrst_PA", 32'(bus.Physical_address), 0);
    tick();
    tick();
    check("mrst_no_issue", 32'(bus.start), 0);
    check("mrst_count_hold", 32'(bus.count), 0);

`ifdef DIV_RS_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      dispatch(4'b0000, 32'(i), 8'(8'hD0 + i), 8'hC0, 32'h0, 1'b0, 8'h00, 32'd1, 1'b1);
      tick();
    end
    idle();
    check("fl_count3", 32'(bus.count), 3);
    flush = 1'b1;
    cdb(8'hC0, 32'd1);
    tick();
    flush = 1'b0;
    idle();
    check("fl_count0", 32'(bus.count), 0);
    check("fl_start0", 32'(bus.start), 0);
    tick();
    check("fl_later0", 32'(bus.start), 0);
    tick();
    check("fl_later1", 32'(bus.start), 0);
    check("fl_count_hold", 32'(bus.count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_rs.md
# div_rs

Reservation station for the pipelined integer divider. It buffers up to DEPTH divide/remainder micro-ops from dispatch and captures missing source operands from the common data bus (CDB). Each cycle it issues the oldest entry whose operands are both ready into the divider's start/A/B/tag/PC/op inputs. The divider is fully pipelined and never back-pressures, so at most one entry issues per cycle.

## Interface
- DEPTH, 8, number of entries (2..16)
- TAG_W, 8, physical register tag width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dispatch_valid  in  1  new micro-op offered
- dispatch_op  in  4  divider op; 4'b0001 = quotient, any other value = remainder
- dispatch_pc  in  32  instruction PC
- dispatch_pdst  in  TAG_W  destination physical tag
- dispatch_src1_tag / dispatch_src2_tag  in  TAG_W  dividend / divisor source tags
- dispatch_src1_val / dispatch_src2_val  in  32  operand values, valid when the matching rdy bit is set
- dispatch_src1_rdy / dispatch_src2_rdy  in  1  operand already available
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  32  broadcast value
- full  out  1  combinational, count == DEPTH
- count  out  $clog2(DEPTH+1)  occupied entries
- start  out  1  registered, issue valid to divider
- A, B  out  32  registered dividend and divisor
- Physical_address  out  TAG_W  registered destination tag
- PC  out  32  registered PC
- divider_op  out  4  registered op

## Operation
- Each entry holds: valid, op, pc, pdst, and for each source a tag, a 32-bit value and a rdy bit.
- The storage is a collapsing queue. Index 0 is always the oldest entry, and valid entries are contiguous from index 0.
- Issue select:
  - The lowest index with valid && rdy1 && rdy2 wins.
  - The winner is removed, and all entries above it shift down by one in the same cycle.
  - The issue registers load the winner's fields with start=1. If there is no winner, start=0 and the other issue registers hold their values.
- Dispatch:
  - Accepted only when dispatch_valid && !full. If full is asserted, the request is ignored and upstream must stall.
  - The new entry is written at index count, or count-1 if an issue occurs in the same cycle.
- Wakeup:
  - When cdb_valid is high, every valid entry with a non-ready source whose tag equals cdb_tag sets rdy=1 and latches cdb_value. Both sources of the same entry may wake on one broadcast.
  - Wakeup is applied to entries after the shift.
- Same-cycle dispatch and broadcast: if an incoming not-ready source tag matches cdb_tag, the source is written as ready with cdb_value. No broadcast may be lost.
- Arithmetic is pass-through only. Divide-by-zero is handled by the divider; the station forwards B=0 unchanged.

## Timing
- Reset values: all entries invalid, count=0, full=0, start=0, A=B=PC=0, Physical_address=0, divider_op=0.
- Reset asserted mid-operation clears everything on the next edge. Any in-flight dispatch or CDB in that cycle is discarded.
- Dispatch with both operands ready in cycle t: the entry is visible in t+1 and start=1 in t+2 (a 2-cycle minimum).
- CDB wakeup in cycle t: the entry becomes eligible in t+1, and start can be 1 in t+2.
- The select logic reads only registered entry state, so a same-cycle wakeup or dispatch never issues in that same cycle.
- Full with a simultaneous issue: dispatch is still rejected that cycle, because full is derived from the registered count. count decrements on the next edge.
- Throughput: one issue per cycle whenever a ready entry exists.

## Configuration
- DIV_RS_FLUSH_EN is defined:
  - Adds input flush (1 bit), used for branch mispredict recovery.
  - A flush in cycle t invalidates all entries, sets count=0 and forces start=0 at the next edge.
  - Dispatch and CDB inputs in cycle t are ignored. flush takes priority over issue.
- DIV_RS_FLUSH_EN is undefined: no flush port exists, and entries leave the station only by issue or reset.

## Structure
- Shared package div_pkg holds:
  - op encodings DIV_OP_QUO=4'b0001 and DIV_OP_REM=4'b0000;
  - TAG_W;
  - the packed entry struct div_rs_entry_t.
- Sub-module div_rs_select: combinational find-first over the DEPTH-bit ready vector. It returns the winner index and a hit flag.
- Queue storage, shift, wakeup and the issue registers stay in div_rs.

## Test plan
- Reset, then dispatch op=0001, A=100, B=7, pdst=0x12, PC=0x40, both rdy -> two cycles later start=1, A=100, B=7, Physical_address=0x12, divider_op=0001; count returns to 0.
- Dispatch src2 not ready with tag 0x33, then CDB tag 0x33, value 5, two cycles later -> no issue before the broadcast; start=1 with B=5 two cycles after the broadcast.
- Same-cycle dispatch (src1 tag 0x21 not ready) and CDB tag 0x21, value 9 -> entry issues with A=9; no hang.
- Two entries with entry 1 ready first, then entry 0 ready -> entry 1 issues first; later, when both are ready in the same cycle, the lower index (older) issues first.
- Fill DEPTH=8 with unready entries -> full=1; a ninth dispatch is dropped and count stays 8; one wakeup causes issue and full deasserts the cycle after.
- With DIV_RS_FLUSH_EN: 3 entries held, flush plus a CDB match in the same cycle -> count=0, start=0 next cycle, and no later issue.
